rvh_tlb_miss_arbiter: RTL and testbench



---
 rtl/rvh_mmu_pkg.sv | 23 ++
 rtl/rvh_rr_arbiter.sv | 65 ++++++
 rtl/rvh_tlb_miss_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_rvh_tlb_miss_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_mmu_pkg.sv
// Shared MMU definitions: default field widths for the TLB miss path, the
// access-type encoding carried with each miss, and the flush serialiser states.
package rvh_mmu_pkg;

    localparam int MMU_ASID_WIDTH     = 16;
    localparam int MMU_VPN_WIDTH      = 27;
    localparam int MMU_TRANS_ID_WIDTH = 3;
    localparam int ACCESS_TYPE_WIDTH  = 2;

    typedef enum logic [ACCESS_TYPE_WIDTH-1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } access_type_e;

    typedef enum logic [1:0] {
        F_IDLE,
        F_DRAIN,
        F_ISSUE,
        F_ACK
    } flush_state_e;

endpackage

// File: rtl/rvh_rr_arbiter.sv
// N-way one-hot arbiter, fixed priority (index 0 highest) or round robin.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   req_i       per-requester request
//   upd_en_i    grant is being consumed; round-robin pointer may advance
//   gnt_o       one-hot grant (combinational, all zero when no request)
//   gnt_idx_o   binary index of the granted requester
module rvh_rr_arbiter #(
    parameter int N        = 2,
    parameter int ARB_MODE = 0,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     req_i,
    input  logic             upd_en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    // Round robin searches from the slot after the last winner, wrapping.
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            if (ARB_MODE == 0) begin
                idx = off;
            end else begin
                idx = (int'(ptr_q) + 1 + off) % N;
            end
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IDX_W'(idx);
            end
        end
    end

    // Pointer moves to the winner only when the grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (upd_en_i && found) begin
            ptr_d = gnt_idx_o;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rvh_tlb_miss_arbiter.sv
// Arbitrates N TLB channels onto the single PTW miss port and serialises
// TLB flushes behind in-flight walks.
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   ch_miss_req_*_i / _o    per-channel miss request (packed, channel i at slice i)
//                           and one-hot combinational accept
//   miss_req_*_o / _rdy_i   registered request to the MMU, channel tag, ready
//   miss_resp_*_i           MMU response valid and channel tag
//   ch_miss_resp_vld_o      one-hot demuxed response valid
//   ch_flush_*_i            per-channel flush request (held until grant) and fields
//   ch_flush_grant_o        one-cycle grant pulse to the flushing channel
//   flush_*_o, flush_grant_i  serialised flush to the MMU and its completion
module rvh_tlb_miss_arbiter
    import rvh_mmu_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int TRANS_ID_WIDTH  = MMU_TRANS_ID_WIDTH,
    parameter int ASID_WIDTH      = MMU_ASID_WIDTH,
    parameter int VPN_WIDTH       = MMU_VPN_WIDTH,
    parameter int ARB_MODE        = 0,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CH_ID_WIDTH    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [N_CH-1:0]                     ch_miss_req_vld_i,
    input  logic [N_CH*TRANS_ID_WIDTH-1:0]      ch_miss_req_trans_id_i,
    input  logic [N_CH*ASID_WIDTH-1:0]          ch_miss_req_asid_i,
    input  logic [N_CH*VPN_WIDTH-1:0]           ch_miss_req_vpn_i,
    input  logic [N_CH*ACCESS_TYPE_WIDTH-1:0]   ch_miss_req_access_type_i,
    output logic [N_CH-1:0]                     ch_miss_req_rdy_o,
    output logic                                miss_req_vld_o,
    output logic [CH_ID_WIDTH-1:0]              miss_req_ch_id_o,
    output logic [TRANS_ID_WIDTH-1:0]           miss_req_trans_id_o,
    output logic [ASID_WIDTH-1:0]               miss_req_asid_o,
    output logic [VPN_WIDTH-1:0]                miss_req_vpn_o,
    output logic [ACCESS_TYPE_WIDTH-1:0]        miss_req_access_type_o,
    input  logic                                miss_req_rdy_i,
    input  logic                                miss_resp_vld_i,
    input  logic [CH_ID_WIDTH-1:0]              miss_resp_ch_id_i,
    output logic [N_CH-1:0]                     ch_miss_resp_vld_o,
    input  logic [N_CH-1:0]                     ch_flush_vld_i,
    input  logic [N_CH-1:0]                     ch_flush_use_asid_i,
    input  logic [N_CH-1:0]                     ch_flush_use_vpn_i,
    input  logic [N_CH*ASID_WIDTH-1:0]          ch_flush_asid_i,
    input  logic [N_CH*VPN_WIDTH-1:0]           ch_flush_vpn_i,
    output logic [N_CH-1:0]                     ch_flush_grant_o,
    output logic                                flush_vld_o,
    output logic                                flush_use_asid_o,
    output logic                                flush_use_vpn_o,
    output logic [ASID_WIDTH-1:0]               flush_asid_o,
    output logic [VPN_WIDTH-1:0]                flush_vpn_o,
    input  logic                                flush_grant_i
);

    localparam int AT_W  = ACCESS_TYPE_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [N_CH-1:0]           arb_gnt;
    logic [CH_ID_WIDTH-1:0]    arb_idx;
    logic                      accept_en, accept, resp_dec;

    logic                      req_vld_q, req_vld_d;
    logic [CH_ID_WIDTH-1:0]    req_ch_q, req_ch_d;
    logic [TRANS_ID_WIDTH-1:0] req_tid_q, req_tid_d;
    logic [ASID_WIDTH-1:0]     req_asid_q, req_asid_d;
    logic [VPN_WIDTH-1:0]      req_vpn_q, req_vpn_d;
    logic [AT_W-1:0]           req_at_q, req_at_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    flush_state_e              fstate_q, fstate_d;
    logic [CH_ID_WIDTH-1:0]    fch_q, fch_d;
    logic                      fuse_asid_q, fuse_asid_d;
    logic                      fuse_vpn_q, fuse_vpn_d;
    logic [ASID_WIDTH-1:0]     fasid_q, fasid_d;
    logic [VPN_WIDTH-1:0]      fvpn_q, fvpn_d;

    rvh_rr_arbiter #(
        .N        (N_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req_i     (ch_miss_req_vld_i),
        .upd_en_i  (accept_en),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // Any pending flush blocks new misses, and the cap uses the registered count.
    always_comb begin
        accept_en = (fstate_q == F_IDLE) && !(|ch_flush_vld_i)
                 && (cnt_q < CNT_W'(MAX_OUTSTANDING))
                 && (!req_vld_q || miss_req_rdy_i);
        accept            = accept_en && (|ch_miss_req_vld_i);
        ch_miss_req_rdy_o = arb_gnt & {N_CH{accept_en}};
    end

    always_comb begin
        req_vld_d  = req_vld_q;
        req_ch_d   = req_ch_q;
        req_tid_d  = req_tid_q;
        req_asid_d = req_asid_q;
        req_vpn_d  = req_vpn_q;
        req_at_d   = req_at_q;
        if (accept) begin
            req_vld_d = 1'b1;
            req_ch_d  = arb_idx;
            for (int i = 0; i < N_CH; i++) begin
                if (arb_gnt[i]) begin
                    req_tid_d  = ch_miss_req_trans_id_i[i*TRANS_ID_WIDTH +: TRANS_ID_WIDTH];
                    req_asid_d = ch_miss_req_asid_i[i*ASID_WIDTH +: ASID_WIDTH];
                    req_vpn_d  = ch_miss_req_vpn_i[i*VPN_WIDTH +: VPN_WIDTH];
                    req_at_d   = ch_miss_req_access_type_i[i*AT_W +: AT_W];
                end
            end
        end else if (miss_req_rdy_i) begin
            req_vld_d = 1'b0;
        end
    end

    // A response arriving with nothing outstanding (e.g. after reset) is
    // ignored by the counter so it cannot wrap below zero.
    always_comb begin
        resp_dec = miss_resp_vld_i && (cnt_q != '0);
        cnt_d    = cnt_q;
        if (accept && !resp_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && resp_dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Out-of-range tags match no channel and are dropped here.
    always_comb begin
        ch_miss_resp_vld_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_miss_resp_vld_o[k] = miss_resp_vld_i && (miss_resp_ch_id_i == CH_ID_WIDTH'(k));
        end
    end

    always_comb begin
        fstate_d         = fstate_q;
        fch_d            = fch_q;
        fuse_asid_d      = fuse_asid_q;
        fuse_vpn_d       = fuse_vpn_q;
        fasid_d          = fasid_q;
        fvpn_d           = fvpn_q;
        flush_vld_o      = 1'b0;
        ch_flush_grant_o = '0;
        case (fstate_q)
            F_IDLE: begin
                if (|ch_flush_vld_i) begin
                    // Descending scan so the lowest requesting index is latched last.
                    for (int i = N_CH - 1; i >= 0; i--) begin
                        if (ch_flush_vld_i[i]) begin
                            fch_d       = CH_ID_WIDTH'(i);
                            fuse_asid_d = ch_flush_use_asid_i[i];
                            fuse_vpn_d  = ch_flush_use_vpn_i[i];
                            fasid_d     = ch_flush_asid_i[i*ASID_WIDTH +: ASID_WIDTH];
                            fvpn_d      = ch_flush_vpn_i[i*VPN_WIDTH +: VPN_WIDTH];
                        end
                    end
                    fstate_d = F_DRAIN;
                end
            end
            F_DRAIN: begin
                // Looking at the next count lets the flush issue the cycle
                // after the last outstanding response.
                if ((cnt_d == '0) && !req_vld_q) begin
                    fstate_d = F_ISSUE;
                end
            end
            F_ISSUE: begin
                flush_vld_o = 1'b1;
                if (flush_grant_i) begin
                    fstate_d = F_ACK;
                end
            end
            F_ACK: begin
                for (int k = 0; k < N_CH; k++) begin
                    ch_flush_grant_o[k] = (fch_q == CH_ID_WIDTH'(k));
                end
                fstate_d = F_IDLE;
            end
            default: fstate_d = F_IDLE;
        endcase
    end

    // NOTE: the payload and latched flush fields are ordinary flops, so they
    // are reset with the control state and every output reads zero out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_vld_q   <= 1'b0;
            req_ch_q    <= '0;
            req_tid_q   <= '0;
            req_asid_q  <= '0;
            req_vpn_q   <= '0;
            req_at_q    <= '0;
            cnt_q       <= '0;
            fstate_q    <= F_IDLE;
            fch_q       <= '0;
            fuse_asid_q <= 1'b0;
            fuse_vpn_q  <= 1'b0;
            fasid_q     <= '0;
            fvpn_q      <= '0;
        end else begin
            req_vld_q   <= req_vld_d;
            req_ch_q    <= req_ch_d;
            req_tid_q   <= req_tid_d;
            req_asid_q  <= req_asid_d;
            req_vpn_q   <= req_vpn_d;
            req_at_q    <= req_at_d;
            cnt_q       <= cnt_d;
            fstate_q    <= fstate_d;
            fch_q       <= fch_d;
            fuse_asid_q <= fuse_asid_d;
            fuse_vpn_q  <= fuse_vpn_d;
            fasid_q     <= fasid_d;
            fvpn_q      <= fvpn_d;
        end
    end

    assign miss_req_vld_o         = req_vld_q;
    assign miss_req_ch_id_o       = req_ch_q;
    assign miss_req_trans_id_o    = req_tid_q;
    assign miss_req_asid_o        = req_asid_q;
    assign miss_req_vpn_o         = req_vpn_q;
    assign miss_req_access_type_o = req_at_q;
    assign flush_use_asid_o       = fuse_asid_q;
    assign flush_use_vpn_o        = fuse_vpn_q;
    assign flush_asid_o           = fasid_q;
    assign flush_vpn_o            = fvpn_q;

endmodule

// File: tb/tb_rvh_tlb_miss_arbiter.sv
// Directed bench: DUT A is fixed priority with a cap of 2, DUT B is round
// robin with a cap of 8; both have three channels.
module tb_rvh_tlb_miss_arbiter;
    import rvh_mmu_pkg::*;

    localparam int NC = 3;
    localparam int TW = 3;
    localparam int AW = 16;
    localparam int VW = 27;
    localparam int CW = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Payload shared by both DUTs
    logic [NC*TW-1:0] p_tid;
    logic [NC*AW-1:0] p_asid;
    logic [NC*VW-1:0] p_vpn;
    logic [NC*2-1:0]  p_acc;
    logic [NC-1:0]    p_fua, p_fuv;
    logic [NC*AW-1:0] p_fasid;
    logic [NC*VW-1:0] p_fvpn;

    // DUT A
    logic [NC-1:0] a_vld, a_rdy, a_rvld_o, a_fvld, a_fgnt;
    logic          a_ovld, a_mrdy, a_rvld, a_f_o, a_fua_o, a_fuv_o, a_fgrant;
    logic [CW-1:0] a_och, a_rch;
    logic [TW-1:0] a_otid;
    logic [AW-1:0] a_oasid, a_fasid_o;
    logic [VW-1:0] a_ovpn, a_fvpn_o;
    logic [1:0]    a_oacc;

    // DUT B
    logic [NC-1:0] b_vld, b_rdy, b_rvld_o, b_fvld, b_fgnt;
    logic          b_ovld, b_mrdy, b_rvld, b_f_o, b_fua_o, b_fuv_o, b_fgrant;
    logic [CW-1:0] b_och, b_rch;
    logic [TW-1:0] b_otid;
    logic [AW-1:0] b_oasid, b_fasid_o;
    logic [VW-1:0] b_ovpn, b_fvpn_o;
    logic [1:0]    b_oacc;

    rvh_tlb_miss_arbiter #(.N_CH(NC), .ARB_MODE(0), .MAX_OUTSTANDING(2)) dut_a (
        .clk(clk), .rstn(rstn),
        .ch_miss_req_vld_i(a_vld), .ch_miss_req_trans_id_i(p_tid), .ch_miss_req_asid_i(p_asid),
        .ch_miss_req_vpn_i(p_vpn), .ch_miss_req_access_type_i(p_acc), .ch_miss_req_rdy_o(a_rdy),
        .miss_req_vld_o(a_ovld), .miss_req_ch_id_o(a_och), .miss_req_trans_id_o(a_otid),
        .miss_req_asid_o(a_oasid), .miss_req_vpn_o(a_ovpn), .miss_req_access_type_o(a_oacc),
        .miss_req_rdy_i(a_mrdy), .miss_resp_vld_i(a_rvld), .miss_resp_ch_id_i(a_rch),
        .ch_miss_resp_vld_o(a_rvld_o), .ch_flush_vld_i(a_fvld), .ch_flush_use_asid_i(p_fua),
        .ch_flush_use_vpn_i(p_fuv), .ch_flush_asid_i(p_fasid), .ch_flush_vpn_i(p_fvpn),
        .ch_flush_grant_o(a_fgnt), .flush_vld_o(a_f_o), .flush_use_asid_o(a_fua_o),
        .flush_use_vpn_o(a_fuv_o), .flush_asid_o(a_fasid_o), .flush_vpn_o(a_fvpn_o),
        .flush_grant_i(a_fgrant)
    );

    rvh_tlb_miss_arbiter #(.N_CH(NC), .ARB_MODE(1), .MAX_OUTSTANDING(8)) dut_b (
        .clk(clk), .rstn(rstn),
        .ch_miss_req_vld_i(b_vld), .ch_miss_req_trans_id_i(p_tid), .ch_miss_req_asid_i(p_asid),
        .ch_miss_req_vpn_i(p_vpn), .ch_miss_req_access_type_i(p_acc), .ch_miss_req_rdy_o(b_rdy),
        .miss_req_vld_o(b_ovld), .miss_req_ch_id_o(b_och), .miss_req_trans_id_o(b_otid),
        .miss_req_asid_o(b_oasid), .miss_req_vpn_o(b_ovpn), .miss_req_access_type_o(b_oacc),
        .miss_req_rdy_i(b_mrdy), .miss_resp_vld_i(b_rvld), .miss_resp_ch_id_i(b_rch),
        .ch_miss_resp_vld_o(b_rvld_o), .ch_flush_vld_i(b_fvld), .ch_flush_use_asid_i(p_fua),
        .ch_flush_use_vpn_i(p_fuv), .ch_flush_asid_i(p_fasid), .ch_flush_vpn_i(p_fvpn),
        .ch_flush_grant_o(b_fgnt), .flush_vld_o(b_f_o), .flush_use_asid_o(b_fua_o),
        .flush_use_vpn_o(b_fuv_o), .flush_asid_o(b_fasid_o), .flush_vpn_o(b_fvpn_o),
        .flush_grant_i(b_fgrant)
    );

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        a_vld = '0; a_mrdy = 1'b0; a_rvld = 1'b0; a_rch = '0; a_fvld = '0; a_fgrant = 1'b0;
        b_vld = '0; b_mrdy = 1'b0; b_rvld = 1'b0; b_rch = '0; b_fvld = '0; b_fgrant = 1'b0;
        p_fua = '0; p_fuv = '0; p_fasid = '0; p_fvpn = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        clear_inputs();
        rstn = 1'b0;
        mid();
        n_vec++; if ({a_ovld, a_och, a_otid, a_oasid, a_ovpn, a_oacc} !== '0) begin
            n_err++; $display("FAIL reset_a_req: got %h want 0", {a_ovld, a_och, a_otid, a_oasid, a_ovpn, a_oacc}); end
        n_vec++; if ({a_rdy, a_rvld_o, a_fgnt, a_f_o, a_fua_o, a_fuv_o, a_fasid_o, a_fvpn_o} !== '0) begin
            n_err++; $display("FAIL reset_a_flush: got %h want 0", {a_rdy, a_rvld_o, a_fgnt, a_f_o, a_fua_o, a_fuv_o, a_fasid_o, a_fvpn_o}); end
        n_vec++; if ({b_ovld, b_och, b_otid, b_oasid, b_ovpn, b_oacc, b_rdy, b_rvld_o, b_fgnt,
                      b_f_o, b_fua_o, b_fuv_o, b_fasid_o, b_fvpn_o} !== '0) begin
            n_err++; $display("FAIL reset_b: some output nonzero"); end
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_fixed();
        apply_reset();
        a_mrdy = 1'b1; a_vld = 3'b011;
        mid();
        n_vec++; if (a_rdy !== 3'b001) begin n_err++; $display("FAIL fixed_rdy_c0: got %b want 001", a_rdy); end
        n_vec++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL fixed_ovld_c0: got %b want 0", a_ovld); end
        tick(); a_vld = 3'b010;
        mid();
        n_vec++; if (a_rdy !== 3'b010) begin n_err++; $display("FAIL fixed_rdy_c1: got %b want 010", a_rdy); end
        n_vec++; if ({a_ovld, a_och, a_otid, a_oasid, a_ovpn, a_oacc} !== {1'b1, 2'd0, 3'd1, 16'h0100, 27'h1000, 2'd0}) begin
            n_err++; $display("FAIL fixed_out_c1: got %h want ch0 payload", {a_ovld, a_och, a_otid, a_oasid, a_ovpn, a_oacc}); end
        tick(); a_vld = 3'b000;
        mid();
        n_vec++; if ({a_ovld, a_och, a_otid, a_oasid, a_ovpn, a_oacc} !== {1'b1, 2'd1, 3'd2, 16'h0101, 27'h1001, 2'd1}) begin
            n_err++; $display("FAIL fixed_out_c2: got %h want ch1 payload", {a_ovld, a_och, a_otid, a_oasid, a_ovpn, a_oacc}); end
        tick();
        mid();
        n_vec++; if (a_ovld !== 1'b0) begin n_err++; $display("FAIL fixed_ovld_c3: got %b want 0", a_ovld); end
    endtask

    task automatic test_cap();
        apply_reset();
        a_vld = 3'b001;
        mid();
        n_vec++; if (a_rdy !== 3'b001) begin n_err++; $display("FAIL cap_rdy_first: got %b want 001", a_rdy); end
        tick(); a_vld = 3'b100;
        mid();
        n_vec++; if (a_rdy !== 3'b000) begin n_err++; $display("FAIL cap_stall_rdy: got %b want 000", a_rdy); end
        tick();
        mid();
        n_vec++; if ({a_ovld, a_och, a_otid} !== {1'b1, 2'd0, 3'd1}) begin
            n_err++; $display("FAIL cap_hold: got %h want %h", {a_ovld, a_och, a_otid}, {1'b1, 2'd0, 3'd1}); end
        tick(); a_mrdy = 1'b1;
        mid();
        n_vec++; if (a_rdy !== 3'b100) begin n_err++; $display("FAIL cap_second: got %b want 100", a_rdy); end
        tick(); a_vld = 3'b110;
        mid();
        n_vec++; if (a_rdy !== 3'b000) begin n_err++; $display("FAIL cap_full: got %b want 000", a_rdy); end
        n_vec++; if (a_och !== 2'd2) begin n_err++; $display("FAIL cap_tag2: got %0d want 2", a_och); end
        tick();
        mid();
        n_vec++; if (a_rdy !== 3'b000) begin n_err++; $display("FAIL cap_full2: got %b want 000", a_rdy); end
        tick(); a_rvld = 1'b1; a_rch = 2'd1;
        mid();
        n_vec++; if (a_rvld_o !== 3'b010) begin n_err++; $display("FAIL cap_demux: got %b want 010", a_rvld_o); end
        n_vec++; if (a_rdy !== 3'b000) begin n_err++; $display("FAIL cap_nobypass: got %b want 000", a_rdy); end
        tick(); a_rvld = 1'b0;
        mid();
        n_vec++; if (a_rdy !== 3'b010) begin n_err++; $display("FAIL cap_after_resp: got %b want 010", a_rdy); end
        tick();
        mid();
        n_vec++; if (a_rdy !== 3'b000) begin n_err++; $display("FAIL cap_refull: got %b want 000", a_rdy); end
        tick(); a_rvld = 1'b1; a_rch = 2'd3; a_vld = 3'b100;
        mid();
        n_vec++; if (a_rvld_o !== 3'b000) begin n_err++; $display("FAIL cap_badtag: got %b want 000", a_rvld_o); end
        tick(); a_rvld = 1'b0;
        mid();
        n_vec++; if (a_rdy !== 3'b100) begin n_err++; $display("FAIL cap_badtag_dec: got %b want 100", a_rdy); end
        tick(); a_vld = '0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order [6];
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        apply_reset();
        b_mrdy = 1'b1; b_vld = 3'b111;
        for (int i = 0; i < 6; i++) begin
            b_rvld = b_ovld;
            b_rch  = b_och;
            mid();
            n_vec++; if (b_rdy !== (3'b001 << exp_order[i])) begin
                n_err++; $display("FAIL rr_grant_%0d: got %b want ch%0d", i, b_rdy, exp_order[i]); end
            if (i > 0) begin
                n_vec++; if ({b_ovld, b_och} !== {1'b1, exp_order[i-1]}) begin
                    n_err++; $display("FAIL rr_tag_%0d: got %b/%0d want 1/%0d", i, b_ovld, b_och, exp_order[i-1]); end
            end
            tick();
        end
        b_vld = '0; b_rvld = 1'b0;
    endtask

    task automatic test_flush_drain();
        apply_reset();
        a_mrdy = 1'b1; a_vld = 3'b001;
        tick(); a_vld = 3'b000;
        tick(); a_vld = 3'b001; a_fvld = 3'b010; p_fua = 3'b010; p_fasid = {16'h0, 16'h0005, 16'h0};
        mid();
        n_vec++; if (a_rdy !== 3'b000) begin n_err++; $display("FAIL fd_flush_beats_miss: got %b want 000", a_rdy); end
        tick();
        mid();
        n_vec++; if ({a_rdy, a_f_o} !== 4'b0000) begin n_err++; $display("FAIL fd_drain: got %b want 0000", {a_rdy, a_f_o}); end
        tick(); a_rvld = 1'b1; a_rch = 2'd0;
        mid();
        n_vec++; if ({a_rvld_o, a_f_o} !== 4'b0010) begin n_err++; $display("FAIL fd_resp: got %b want 0010", {a_rvld_o, a_f_o}); end
        tick(); a_rvld = 1'b0; a_fgrant = 1'b1;
        mid();
        n_vec++; if ({a_f_o, a_fua_o, a_fuv_o, a_fasid_o} !== {3'b110, 16'h0005}) begin
            n_err++; $display("FAIL fd_issue: got %h want %h", {a_f_o, a_fua_o, a_fuv_o, a_fasid_o}, {3'b110, 16'h0005}); end
        n_vec++; if (a_rdy !== 3'b000) begin n_err++; $display("FAIL fd_issue_rdy: got %b want 000", a_rdy); end
        tick(); a_fgrant = 1'b0;
        mid();
        n_vec++; if ({a_fgnt, a_f_o} !== 4'b0100) begin n_err++; $display("FAIL fd_ack: got %b want 0100", {a_fgnt, a_f_o}); end
        tick(); a_fvld = '0;
        mid();
        n_vec++; if ({a_fgnt, a_rdy} !== 6'b000001) begin n_err++; $display("FAIL fd_idle: got %b want 000001", {a_fgnt, a_rdy}); end
        tick(); a_vld = '0;
    endtask

    task automatic test_flush_two();
        apply_reset();
        p_fua = 3'b001; p_fuv = 3'b100;
        p_fasid = {16'h000C, 16'h0000, 16'h000A};
        p_fvpn  = {27'h0000123, 27'h0, 27'h0};
        a_fvld  = 3'b101;
        mid();
        n_vec++; if (a_f_o !== 1'b0) begin n_err++; $display("FAIL f2_idle: got %b want 0", a_f_o); end
        tick();
        mid();
        n_vec++; if (a_f_o !== 1'b0) begin n_err++; $display("FAIL f2_drain0: got %b want 0", a_f_o); end
        tick(); a_fgrant = 1'b1;
        mid();
        n_vec++; if ({a_f_o, a_fua_o, a_fuv_o, a_fasid_o} !== {3'b110, 16'h000A}) begin
            n_err++; $display("FAIL f2_issue0: got %h want %h", {a_f_o, a_fua_o, a_fuv_o, a_fasid_o}, {3'b110, 16'h000A}); end
        tick(); a_fgrant = 1'b0;
        mid();
        n_vec++; if (a_fgnt !== 3'b001) begin n_err++; $display("FAIL f2_ack0: got %b want 001", a_fgnt); end
        tick(); a_fvld = 3'b100;
        mid();
        n_vec++; if ({a_fgnt, a_f_o} !== 4'b0000) begin n_err++; $display("FAIL f2_gap: got %b want 0000", {a_fgnt, a_f_o}); end
        tick();
        mid();
        n_vec++; if (a_f_o !== 1'b0) begin n_err++; $display("FAIL f2_drain2: got %b want 0", a_f_o); end
        tick(); a_fgrant = 1'b1;
        mid();
        n_vec++; if ({a_f_o, a_fua_o, a_fuv_o, a_fasid_o, a_fvpn_o} !== {3'b101, 16'h000C, 27'h0000123}) begin
            n_err++; $display("FAIL f2_issue2: got %h want %h", {a_f_o, a_fua_o, a_fuv_o, a_fasid_o, a_fvpn_o},
                              {3'b101, 16'h000C, 27'h0000123}); end
        tick(); a_fgrant = 1'b0;
        mid();
        n_vec++; if (a_fgnt !== 3'b100) begin n_err++; $display("FAIL f2_ack2: got %b want 100", a_fgnt); end
        tick(); a_fvld = '0;
    endtask

    task automatic test_reset_mid_walk();
        apply_reset();
        a_mrdy = 1'b1; a_vld = 3'b001;
        tick(); a_vld = 3'b010;
        tick(); a_vld = 3'b000; a_mrdy = 1'b0; a_fvld = 3'b001; p_fua = 3'b001; p_fasid = {32'h0, 16'h0033};
        tick();
        mid();
        n_vec++; if ({a_ovld, a_f_o} !== 2'b10) begin n_err++; $display("FAIL rm_pre: got %b want 10", {a_ovld, a_f_o}); end
        tick();
        clear_inputs();
        rstn = 1'b0;
        #1;
        n_vec++; if ({a_ovld, a_och, a_otid, a_oasid, a_ovpn, a_oacc, a_rdy, a_fgnt, a_f_o, a_fasid_o} !== '0) begin
            n_err++; $display("FAIL rm_reset_out: some output nonzero"); end
        tick();
        tick();
        rstn = 1'b1;
        a_rvld = 1'b1; a_rch = 2'd0;
        mid();
        n_vec++; if (a_rvld_o !== 3'b001) begin n_err++; $display("FAIL rm_stale_demux: got %b want 001", a_rvld_o); end
        tick(); a_rvld = 1'b0; a_mrdy = 1'b1; a_vld = 3'b001;
        mid();
        n_vec++; if (a_rdy !== 3'b001) begin n_err++; $display("FAIL rm_acc1: got %b want 001", a_rdy); end
        tick(); a_vld = 3'b010;
        mid();
        n_vec++; if (a_rdy !== 3'b010) begin n_err++; $display("FAIL rm_acc2: got %b want 010", a_rdy); end
        tick(); a_vld = 3'b100;
        mid();
        n_vec++; if (a_rdy !== 3'b000) begin n_err++; $display("FAIL rm_cap: got %b want 000", a_rdy); end
        tick(); a_vld = '0;
    endtask

    initial begin
        p_tid  = {3'd3, 3'd2, 3'd1};
        p_asid = {16'h0102, 16'h0101, 16'h0100};
        p_vpn  = {27'h1002, 27'h1001, 27'h1000};
        p_acc  = {ACC_STORE, ACC_LOAD, ACC_FETCH};
        test_reset();
        test_fixed();
        test_cap();
        test_round_robin();
        test_flush_drain();
        test_flush_two();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
